// File: rtl/rv_pkg.sv
// Shared definitions for the integer register file: default widths, the
// architectural register-index type and the hardwired-zero index.
package rv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0] reg_idx_t;

    localparam reg_idx_t X0 = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, x0 forcing, optional write bypass
// and busy lookup for the operand it serves.
module regfile_read_port
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] regs [NREGS],
    input  logic [NREGS-1:0] busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_rd,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] value,
    output logic            busy_out
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(X0);

    logic hit;

    // NOTE: every output gets a default first so no path through the
    // conditions below can leave a latch behind.
    always_comb begin
        hit      = (BYPASS != 0) && wr_en && (wr_rd == addr);
        value    = regs[addr];
        busy_out = busy[addr];
        if (addr == ZERO_IDX) begin
            value    = '0;
            busy_out = 1'b0;
        end else if (hit) begin
            // The in-flight write is the producer being retired this cycle.
            value    = wr_data;
            busy_out = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with hardwired x0, optional write-to-read
// bypass and a per-register busy scoreboard for decode stall detection.
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write_en,
    input  logic [AW-1:0]         rd,
    input  logic [XLEN-1:0]       rd_value,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_value,
    output logic [NREAD-1:0]      rs_busy,
    input  logic                  mark_en,
    input  logic [AW-1:0]         mark_rd,
    output logic [AW:0]           busy_count,
    output logic                  any_busy
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(X0);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      count_next;
    logic             wr_fire;
    logic             mark_fire;

    assign wr_fire   = reg_write_en && (rd != ZERO_IDX);
    assign mark_fire = mark_en && (mark_rd != ZERO_IDX);

    // NOTE: the array is cleared by the asynchronous reset, so it must be a
    // flop array rather than an SRAM macro; that is what makes reads 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[rd] <= rd_value;
        end
    end

    // Clear is applied before set so a same-cycle re-issue keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (wr_fire) begin
            busy_next[rd] = 1'b0;
        end
        if (mark_fire) begin
            busy_next[mark_rd] = 1'b1;
        end
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            count_next = count_next + (AW+1)'(busy_next[i]);
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples values
    // from before the edge, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    assign any_busy = (busy_count != '0);

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        regfile_read_port #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .BYPASS (BYPASS)
        ) u_port (
            .addr     (rs_addr[k*AW +: AW]),
            .regs     (regs),
            .busy     (busy),
            .wr_en    (wr_fire && !rst),
            .wr_rd    (rd),
            .wr_data  (rd_value),
            .value    (rs_value[k*XLEN +: XLEN]),
            .busy_out (rs_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: stimulus pushes expected outputs from an array-based model,
// a monitor process pops and compares them against three DUT configurations.
module tb_regfile_scoreboard;
    import rv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        reg_write_en;
    reg_idx_t    rd;
    logic [31:0] rd_value;
    logic [9:0]  rs_addr;
    logic        mark_en;
    reg_idx_t    mark_rd;

    logic [63:0] rs_value,    nb_rs_value;
    logic [1:0]  rs_busy,     nb_rs_busy;
    logic [5:0]  busy_count,  nb_busy_count;
    logic        any_busy,    nb_any_busy;

    logic         w_we;
    logic [3:0]   w_rd;
    logic [63:0]  w_val;
    logic [11:0]  w_addr;
    logic [191:0] w_value;
    logic [2:0]   w_busy;
    logic [4:0]   w_count;
    logic         w_any;

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .reg_write_en(reg_write_en), .rd(rd), .rd_value(rd_value),
        .rs_addr(rs_addr), .rs_value(rs_value), .rs_busy(rs_busy), .mark_en(mark_en),
        .mark_rd(mark_rd), .busy_count(busy_count), .any_busy(any_busy)
    );

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .reg_write_en(reg_write_en), .rd(rd), .rd_value(rd_value),
        .rs_addr(rs_addr), .rs_value(nb_rs_value), .rs_busy(nb_rs_busy), .mark_en(mark_en),
        .mark_rd(mark_rd), .busy_count(nb_busy_count), .any_busy(nb_any_busy)
    );

    regfile_scoreboard #(.XLEN(64), .NREGS(16), .NREAD(3), .BYPASS(1)) u_wide (
        .clk(clk), .rst(rst), .reg_write_en(w_we), .rd(w_rd), .rd_value(w_val),
        .rs_addr(w_addr), .rs_value(w_value), .rs_busy(w_busy), .mark_en(1'b0),
        .mark_rd(4'd0), .busy_count(w_count), .any_busy(w_any)
    );

    typedef struct {
        string       name;
        logic [31:0] v  [2];
        logic [1:0]  b;
        logic [31:0] nv [2];
        logic [1:0]  nb;
        logic [5:0]  cnt;
        logic        any;
    } exp_t;

    typedef struct {
        string       name;
        logic [63:0] v [3];
    } wexp_t;

    exp_t  exp_q [$];
    wexp_t wexp_q[$];
    event  ev_chk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: architectural state as plain arrays.
    logic [31:0] m_reg  [32];
    bit          m_busy [32];
    logic [63:0] m_wreg [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void clear_model();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        for (int i = 0; i < 16; i++) m_wreg[i] = '0;
    endfunction

    // Architectural effect of one clock edge.
    function automatic void commit();
        if (reg_write_en && rd != 0) begin
            m_reg[rd]  = rd_value;
            m_busy[rd] = 1'b0;
        end
        if (mark_en && mark_rd != 0) m_busy[mark_rd] = 1'b1;
        if (w_we && w_rd != 0) m_wreg[w_rd] = w_val;
    endfunction

    function automatic exp_t expect_main(input string name);
        exp_t e;
        int   cnt = 0;
        e.name = name;
        e.b    = '0;
        e.nb   = '0;
        for (int k = 0; k < 2; k++) begin
            logic [4:0] a;
            a = rs_addr[k*5 +: 5];
            e.v[k]  = '0;
            e.nv[k] = '0;
            if (!rst && a != 0) begin
                e.nv[k] = m_reg[a];
                e.nb[k] = m_busy[a];
                if (reg_write_en && rd == a) begin
                    e.v[k] = rd_value;
                    e.b[k] = 1'b0;
                end else begin
                    e.v[k] = m_reg[a];
                    e.b[k] = m_busy[a];
                end
            end
        end
        for (int i = 0; i < 32; i++) cnt += int'(m_busy[i]);
        e.cnt = 6'(cnt);
        e.any = (cnt != 0);
        return e;
    endfunction

    function automatic wexp_t expect_wide(input string name);
        wexp_t e;
        e.name = name;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] a;
            a = w_addr[k*4 +: 4];
            if (rst || a == 0)            e.v[k] = '0;
            else if (w_we && w_rd == a)   e.v[k] = w_val;
            else                          e.v[k] = m_wreg[a];
        end
        return e;
    endfunction

    initial begin : monitor
        exp_t  e;
        wexp_t w;
        forever begin
            @(ev_chk);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("%s val%0d", e.name, k), 64'(rs_value[k*32 +: 32]), 64'(e.v[k]));
                    check($sformatf("%s busy%0d", e.name, k), 64'(rs_busy[k]), 64'(e.b[k]));
                    check($sformatf("%s nb_val%0d", e.name, k), 64'(nb_rs_value[k*32 +: 32]), 64'(e.nv[k]));
                    check($sformatf("%s nb_busy%0d", e.name, k), 64'(nb_rs_busy[k]), 64'(e.nb[k]));
                end
                check({e.name, " count"}, 64'(busy_count), 64'(e.cnt));
                check({e.name, " any"}, 64'(any_busy), 64'(e.any));
                check({e.name, " nb_count"}, 64'(nb_busy_count), 64'(e.cnt));
            end
            while (wexp_q.size() > 0) begin
                w = wexp_q.pop_front();
                for (int k = 0; k < 3; k++)
                    check($sformatf("%s val%0d", w.name, k), w_value[k*64 +: 64], w.v[k]);
                check({w.name, " busy"}, 64'(w_busy), 64'd0);
                check({w.name, " count"}, 64'({w_any, w_count}), 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        if (!rst) commit();
        #1;
    endtask

    task automatic push_all(input string name);
        exp_q.push_back(expect_main(name));
        wexp_q.push_back(expect_wide({name, " wide"}));
        ->ev_chk;
    endtask

    task automatic drive(input bit we, input logic [4:0] r, input logic [31:0] val,
                         input bit mk, input logic [4:0] mr,
                         input logic [4:0] a0, input logic [4:0] a1, input string name);
        step();
        reg_write_en = we;
        rd           = r;
        rd_value     = val;
        mark_en      = mk;
        mark_rd      = mr;
        rs_addr      = {a1, a0};
        exp_q.push_back(expect_main(name));
        ->ev_chk;
    endtask

    task automatic wdrive(input bit we, input logic [3:0] r, input logic [63:0] val,
                          input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                          input string name);
        step();
        w_we   = we;
        w_rd   = r;
        w_val  = val;
        w_addr = {a2, a1, a0};
        wexp_q.push_back(expect_wide(name));
        ->ev_chk;
    endtask

    // Asserts reset between edges with whatever inputs are currently applied.
    task automatic reset_pulse(input string name);
        step();
        rst = 1'b1;
        clear_model();
        push_all({name, " asserted"});
        step();
        rst = 1'b0;
        push_all({name, " released"});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        rst = 1'b1;
        reg_write_en = 1'b0; rd = '0; rd_value = '0; rs_addr = '0; mark_en = 1'b0; mark_rd = '0;
        w_we = 1'b0; w_rd = '0; w_val = '0; w_addr = '0;
        clear_model();
        #1;
        push_all("por");
        step();
        rst = 1'b0;
        push_all("por released");

        drive(1, 1, 32'hff00_aa55, 0, 0, 0, 0, "wr_r1");
        drive(1, 5, 32'h1234_5678, 0, 0, 1, 5, "wr_r5");
        drive(0, 0, 32'h0, 0, 0, 1, 5, "rd_1_5");
        drive(1, 0, 32'hdead_beef, 0, 0, 0, 0, "wr_r0");
        drive(0, 0, 32'h0, 0, 0, 0, 0, "rd_r0");
        drive(1, 7, 32'hcafe_0001, 0, 0, 1, 7, "bypass_r7");
        drive(0, 0, 32'h0, 0, 0, 7, 7, "after_r7");

        drive(0, 0, 32'h0, 1, 3, 3, 3, "mark3");
        drive(0, 0, 32'h0, 0, 0, 3, 0, "busy3");
        drive(1, 3, 32'h0000_0333, 0, 0, 3, 3, "wr3");
        drive(0, 0, 32'h0, 0, 0, 3, 3, "clr3");
        drive(1, 3, 32'h0000_0444, 1, 3, 3, 0, "mark_wr3");
        drive(0, 0, 32'h0, 0, 0, 3, 3, "still_busy3");
        drive(0, 0, 32'h0, 1, 0, 0, 3, "mark0");
        drive(0, 0, 32'h0, 0, 0, 0, 3, "after_mark0");

        drive(1, 9, 32'h9999_9999, 1, 9, 1, 9, "pre_rst");
        reset_pulse("rst_contents");
        drive(0, 0, 32'h0, 0, 0, 1, 9, "post_rst");

        for (int i = 1; i < 32; i++)
            drive(0, 0, 32'h0, 1, 5'(i), 5'(i), 5'(i - 1), $sformatf("mark_%0d", i));
        drive(0, 0, 32'h0, 1, 0, 31, 0, "count_full");
        drive(0, 0, 32'h0, 0, 0, 17, 30, "count_hold");
        for (int i = 1; i <= 10; i++)
            drive(0, 0, 32'h0, 1, 5'(i), 5'(i), 0, $sformatf("remark_%0d", i));
        reset_pulse("rst_mid");

        for (int n = 0; n < 400; n++) begin
            logic [4:0] r, a0, a1;
            r  = 5'($urandom_range(0, 31));
            a0 = ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), r, $urandom(), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), a0, a1, $sformatf("rand_%0d", n));
        end
        drive(0, 0, 32'h0, 0, 0, 0, 0, "idle");

        wdrive(1, 15, 64'h0123_4567_89ab_cdef, 15, 15, 15, "w_bypass15");
        wdrive(0, 0, 64'h0, 15, 15, 15, "w_rd15");
        for (int n = 0; n < 40; n++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            wdrive(1'($urandom_range(0, 1)), r, {$urandom(), $urandom()},
                   4'($urandom_range(0, 15)), r, 4'($urandom_range(0, 15)),
                   $sformatf("w_rand_%0d", n));
        end

        step();
        step();
        check("queue_drain", 64'(exp_q.size() + wexp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
